// File: rtl/ifm_bram_read_sequencer.sv
// IFM BRAM read sequencer: walks a rows x words window and streams it over valid/ready.
// Define IFM_RD_SEQ_PERF_EN to add the saturating stall_cnt output.

module ifm_bram_read_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  row_len,
  input  logic [CNT_WIDTH-1:0]  num_rows,
  input  logic [ADDR_WIDTH-1:0] row_stride,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef IFM_RD_SEQ_PERF_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] r_row_base;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [CNT_WIDTH-1:0]  r_row_len;
  logic [CNT_WIDTH-1:0]  r_num_rows;
  logic [CNT_WIDTH-1:0]  r_word_cnt;
  logic [CNT_WIDTH-1:0]  r_row_cnt;

  logic                  r_inflight;
  logic                  r_inflight_last;

  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic                  r_fifo_last [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic                  w_start;
  logic                  w_pop;
  logic                  w_push;
  logic [1:0]            w_occ;
  logic                  w_issue;
  logic                  w_last_word;
  logic                  w_last_row;
  logic                  w_final;
  logic                  w_empty;
  logic [ADDR_WIDTH-1:0] w_next_row;

  assign w_start     = (r_state == S_IDLE) & start;
  assign w_empty     = (r_count == 2'd0);
  assign w_pop       = !w_empty & m_ready;
  assign w_push      = r_inflight;
  assign w_last_word = (r_word_cnt == r_row_len - CNT_ONE);
  assign w_last_row  = (r_row_cnt == r_num_rows - CNT_ONE);
  assign w_final     = w_last_word & w_last_row;
  assign w_next_row  = r_row_base + r_stride;

  // Occupancy net of this cycle's pop, so a draining FIFO keeps 1 word/cycle.
  assign w_occ   = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue = (r_state == S_RUN) & (w_occ < 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_issue && w_final) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_empty && !r_inflight) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_RUN: begin
        busy = 1'b1;
      end
      S_DRAIN: begin
        busy = 1'b1;
        done = w_empty & !r_inflight;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_addr  <= '0;
      r_row_base <= '0;
      r_stride   <= '0;
      r_row_len  <= '0;
      r_num_rows <= '0;
      r_word_cnt <= '0;
      r_row_cnt  <= '0;
    end else if (w_start) begin
      r_rd_addr  <= base_addr;
      r_row_base <= base_addr;
      r_stride   <= row_stride;
      r_row_len  <= row_len;
      r_num_rows <= num_rows;
      r_word_cnt <= '0;
      r_row_cnt  <= '0;
    end else if (w_issue) begin
      if (w_last_word) begin
        r_row_base <= w_next_row;
        r_rd_addr  <= w_next_row;
        r_word_cnt <= '0;
        r_row_cnt  <= r_row_cnt + CNT_ONE;
      end else begin
        r_rd_addr  <= r_rd_addr + WORD_BYTES;
        r_word_cnt <= r_word_cnt + CNT_ONE;
      end
    end
  end

  // One read can be in flight; its last flag travels with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_final;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last[0] <= 1'b0;
      r_fifo_last[1] <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= bram_rdata;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign rd_addr = r_rd_addr;
  assign m_valid = !w_empty;
  assign m_data  = r_fifo_data[r_rd_ptr];
  assign m_last  = r_fifo_last[r_rd_ptr] & !w_empty;

`ifdef IFM_RD_SEQ_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_start) begin
      r_stall_cnt <= '0;
    end else if ((r_state != S_IDLE) && m_valid && !m_ready
                 && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ifm_bram_read_sequencer.sv
// Directed bench for ifm_bram_read_sequencer with a 1-cycle BRAM model.
// Stall counter checks are active when IFM_RD_SEQ_PERF_EN is defined.

module tb_ifm_bram_read_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] row_len;
  logic [15:0] num_rows;
  logic [31:0] row_stride;
  logic        busy;
  logic        done;
  logic [31:0] rd_addr;
  logic [31:0] bram_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
`ifdef IFM_RD_SEQ_PERF_EN
  logic [31:0] stall_cnt;
`endif

  ifm_bram_read_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .row_len    (row_len),
    .num_rows   (num_rows),
    .row_stride (row_stride),
    .busy       (busy),
    .done       (done),
    .rd_addr    (rd_addr),
    .bram_rdata (bram_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
`ifdef IFM_RD_SEQ_PERF_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [29:0] idx);
    return 32'hA5C3_0000 ^ {2'b00, idx} ^ {idx[15:0], 16'h0000};
  endfunction

  always @(posedge clk) bram_rdata <= memf(rd_addr[31:2]);

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ready pattern: mode 0 always ready, mode 1 toggles with a 5-cycle low stretch.
  int rmode = 0;
  int rcyc = 0;
  always @(posedge clk) begin
    #1;
    rcyc++;
    if (rmode == 0) m_ready = 1'b1;
    else if (rcyc >= 6 && rcyc < 11) m_ready = 1'b0;
    else m_ready = (rcyc % 2) == 1;
  end

  logic [31:0] got_d[$];
  logic        got_l[$];
  logic [31:0] exp_a[$];
  int          stalls, dones, done_cyc, ncyc, hold_err;
  bit          mon_en = 1'b0;
  bit          hold_pend = 1'b0;
  logic [31:0] hold_d;
  logic        hold_l;

  always @(negedge clk) begin
    if (mon_en) begin
      ncyc++;
      if (hold_pend && (!m_valid || m_data !== hold_d || m_last !== hold_l))
        hold_err++;
      hold_pend = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
      end
      if (busy && m_valid && !m_ready) stalls++;
      if (done) begin
        dones++;
        if (dones == 1) done_cyc = ncyc;
      end
    end
  end

  task automatic run(input logic [31:0] base, input logic [15:0] rl,
                     input logic [15:0] nr, input logic [31:0] stride,
                     input int mode, input bit restart, input string nm);
    int n;
    n = exp_a.size();
    @(posedge clk); #1;
    got_d.delete();
    got_l.delete();
    stalls = 0; dones = 0; done_cyc = 0; ncyc = 0; hold_err = 0;
    hold_pend = 1'b0;
    rmode = mode;
    rcyc = 0;
    start = 1'b1;
    base_addr = base; row_len = rl; num_rows = nr; row_stride = stride;
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = $urandom; row_len = 16'($urandom);
    num_rows = 16'($urandom); row_stride = $urandom;
    check({nm, ":busy1"}, 64'(busy), 64'd1);
`ifdef IFM_RD_SEQ_PERF_EN
    check({nm, ":stall_clr"}, 64'(stall_cnt), 64'd0);
`endif
    if (mode == 0) check({nm, ":vld_c1"}, 64'(m_valid), 64'd0);
    @(posedge clk); #1;
    if (restart) start = 1'b1;
    if (mode == 0) check({nm, ":vld_c2"}, 64'(m_valid), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    if (mode == 0) begin
      check({nm, ":vld_c3"}, 64'(m_valid), 64'd1);
      check({nm, ":data_c3"}, 64'(m_data), 64'(memf(exp_a[0][31:2])));
    end
    for (int i = 0; i < 400 && dones == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check({nm, ":done_cnt"}, 64'(dones), 64'd1);
    if (mode == 0) check({nm, ":done_cyc"}, 64'(done_cyc), 64'(n + 4));
    check({nm, ":busy_end"}, 64'(busy), 64'd0);
    check({nm, ":nwords"}, 64'(got_d.size()), 64'(n));
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      check($sformatf("%s:d%0d", nm, i), 64'(got_d[i]),
            64'(memf(exp_a[i][31:2])));
      check($sformatf("%s:l%0d", nm, i), 64'(got_l[i]),
            64'(i == n - 1));
    end
    check({nm, ":hold"}, 64'(hold_err), 64'd0);
`ifdef IFM_RD_SEQ_PERF_EN
    check({nm, ":stall_cnt"}, 64'(stall_cnt), 64'(stalls));
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; m_ready = 1'b1;
    base_addr = '0; row_len = '0; num_rows = '0; row_stride = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:done", 64'(done), 64'd0);
    check("rst:vld", 64'(m_valid), 64'd0);
    check("rst:last", 64'(m_last), 64'd0);
    check("rst:addr", 64'(rd_addr), 64'd0);
    check("rst:data", 64'(m_data), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst:busy_after", 64'(busy), 64'd0);

    exp_a = '{32'h100, 32'h104, 32'h108, 32'h10C};
    run(32'h100, 16'd4, 16'd1, 32'h0, 0, 1'b0, "t1");

    exp_a = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44, 32'h48};
    run(32'h0, 16'd3, 16'd2, 32'h40, 0, 1'b0, "t2");
    run(32'h0, 16'd3, 16'd2, 32'h40, 1, 1'b0, "t3");

    exp_a = '{32'hFFFF_FFFC};
    run(32'hFFFF_FFFC, 16'd1, 16'd1, 32'h40, 0, 1'b1, "t4");

    @(posedge clk); #1;
    rmode = 0;
    start = 1'b1; base_addr = 32'h300; row_len = 16'd4;
    num_rows = 16'd4; row_stride = 32'h40;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t5:busy_mid", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("t5:busy_rst", 64'(busy), 64'd0);
    check("t5:vld_rst", 64'(m_valid), 64'd0);
    check("t5:done_rst", 64'(done), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t5:busy_post", 64'(busy), 64'd0);
    check("t5:vld_post", 64'(m_valid), 64'd0);
    check("t5:done_post", 64'(done), 64'd0);

    exp_a.delete();
    for (int r = 0; r < 4; r++)
      for (int w = 0; w < 4; w++)
        exp_a.push_back(32'h200 + 32'(r) * 32'h40 + 32'(w) * 32'd4);
    run(32'h200, 16'd4, 16'd4, 32'h40, 0, 1'b0, "t5");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
